ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAM port between two requesters: the CPU data port (load/store/pointer traffic) and the video scanout fetch unit, which reads the framebuffer.
- Arbitrates each cycle and registers the winning command onto the RAM port.
- Tracks in-flight reads in a tag pipeline and returns read data to the requester that issued it.
- CPU has default priority. A wait counter guarantees video a grant within MAX_WAIT cycles.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- READ_LAT, 1, cycles from the cycle ram_en is high to the cycle ram_rdata is valid (range 1..4).
- MAX_WAIT, 8, consecutive cycles video may be refused before it takes priority (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; request accepted at this clock edge.
- cpu_rvalid  out  1  CPU read data valid this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- vid_req  in  1  video read request; held with vid_addr stable until vid_gnt.
- vid_addr  in  ADDR_W  video read address.
- vid_gnt  out  1  combinational grant to video.
- vid_rvalid  out  1  video read data valid this cycle.
- vid_rdata  out  DATA_W  video read data.
- ram_en  out  1  registered RAM access strobe.
- ram_we  out  1  registered RAM write enable.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid READ_LAT cycles after ram_en.

Behaviour:
- Reset (reset low, asynchronous):
  - ram_en, ram_we, ram_addr, ram_wdata = 0.
  - cpu_rvalid, vid_rvalid = 0.
  - Wait counter = 0; tag pipeline cleared.
  - Reads in flight are dropped and no rvalid is issued for them.
  - gnt outputs are 0 while reset is low.
- Arbitration (combinational, every cycle):
  - vid_req high and wait counter == MAX_WAIT: vid_gnt = 1 (video is starved and wins).
  - Otherwise, cpu_req high: cpu_gnt = 1.
  - Otherwise, vid_req high: vid_gnt = 1.
  - At most one gnt is high in any cycle. A request with no gnt stays pending.
- Issue (edge after a grant in cycle N):
  - In cycle N+1: ram_en = 1, ram_addr = winner's address.
  - CPU winner: ram_we = cpu_we, ram_wdata = cpu_wdata.
  - Video winner: ram_we = 0, ram_wdata = 0.
  - No grant in cycle N: ram_en = 0, ram_we = 0; ram_addr and ram_wdata hold their previous values.
- Wait counter:
  - Increments, saturating at MAX_WAIT, in each cycle where vid_req = 1 and vid_gnt = 0.
  - Clears to 0 on vid_gnt, or when vid_req = 0.
- Read return:
  - Tag pipeline is READ_LAT+1 stages. Each stage holds {valid, owner}. Writes push valid = 0.
  - A read granted in cycle N returns in cycle N+1+READ_LAT: the owner's rvalid = 1 and its rdata = ram_rdata (combinational pass-through).
  - Non-owner rvalid = 0. rdata outputs are don't-care when their rvalid is low.
- Throughput:
  - One grant per cycle; back-to-back grants are allowed.
  - Returns complete in grant order, one per cycle maximum.
- Simultaneous events:
  - A grant and a return in the same cycle are independent.
  - A new request on the cycle its own previous read returns is legal.
- Write-then-read to the same address on consecutive grants: the read returns the new data, because the RAM serves operations in order.

Decomposition:
- Shared package holds:
  - an owner enum: OWNER_CPU = 0, OWNER_VID = 1;
  - the tag struct {valid, owner};
  - default ADDR_W and DATA_W constants.
- One sub-module, rd_tag_pipe: a parameterised shift register of tag structs, depth READ_LAT+1, with asynchronous active-low clear. It produces the registered rvalid and owner.

Test Plan:
- Reset: hold reset low 3 cycles with both reqs high -> both gnt = 0, ram_en = 0, both rvalid = 0. Release reset -> cpu_gnt = 1 on the first cycle.
- CPU write then read, READ_LAT = 1:
  - cpu_req/we = 1, addr 0x3000, data 0xBEEF -> ram_en = ram_we = 1, addr 0x3000 next cycle.
  - Then a read of 0x3000 -> cpu_rvalid = 1 with cpu_rdata = 0xBEEF exactly 2 cycles after its grant.
- Video alone: vid_req with addr 0xC000 for 4 consecutive addresses -> 4 back-to-back vid_gnt. vid_rvalid returns in order. cpu_rvalid stays 0 throughout.
- Starvation, MAX_WAIT = 8: cpu_req and vid_req held continuously -> cpu_gnt for 8 cycles, vid_gnt on cycle 9, counter back to 0, CPU wins on cycle 10.
- Mixed in flight, READ_LAT = 3: alternate CPU read 0x0010 and video read 0xC000 -> each rvalid asserts only at its owner, 4 cycles after its grant.
- Reset mid-flight: assert reset 1 cycle after a CPU read grant -> no cpu_rvalid ever appears for that read; ram_en = 0 immediately.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: request owner and in-flight read tag.
// Default bus widths live here so the top and the bench agree.
package ram_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_VID = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Shift register of read tags that follows each RAM access until its data returns.
// The last stage lines up with the cycle ram_rdata is valid for that access.
module rd_tag_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output logic    out_valid,
    output owner_e  out_owner
);

    rd_tag_t [DEPTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[DEPTH-2:0], tag_in};
        end
    end

    assign out_valid = stage_reg[DEPTH-1].valid;
    assign out_owner = stage_reg[DEPTH-1].owner;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU data port and video scanout fetch.
// CPU wins by default; a saturating wait counter forces a video grant after MAX_WAIT refusals.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic              ram_en_reg, ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    rd_tag_t           tag_in;
    logic              ret_valid;
    owner_e            ret_owner;

    // Grants are forced low while reset is asserted so nothing is accepted then.
    always_comb begin
        cpu_gnt = 1'b0;
        vid_gnt = 1'b0;
        if (reset) begin
            if (vid_req && wait_cnt_reg == MAX_WAIT_C) begin
                vid_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (vid_req) begin
                vid_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!vid_req || vid_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != MAX_WAIT_C) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg  <= '0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            ram_en_reg   <= cpu_gnt | vid_gnt;
            ram_we_reg   <= cpu_gnt & cpu_we;
            if (cpu_gnt) begin
                ram_addr_reg  <= cpu_addr;
                ram_wdata_reg <= cpu_wdata;
            end else if (vid_gnt) begin
                ram_addr_reg  <= vid_addr;
                ram_wdata_reg <= '0;
            end
        end
    end

    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;

    // Writes enter the pipe as bubbles so returns stay aligned with grant order.
    always_comb begin
        tag_in.valid = (cpu_gnt & ~cpu_we) | vid_gnt;
        tag_in.owner = vid_gnt ? OWNER_VID : OWNER_CPU;
    end

    rd_tag_pipe #(
        .DEPTH(READ_LAT + 1)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .tag_in   (tag_in),
        .out_valid(ret_valid),
        .out_owner(ret_owner)
    );

    assign cpu_rvalid = ret_valid && (ret_owner == OWNER_CPU);
    assign vid_rvalid = ret_valid && (ret_owner == OWNER_VID);
    assign cpu_rdata  = ram_rdata;
    assign vid_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: two instances (READ_LAT 1 and 3) share one stimulus,
// each backed by its own behavioural RAM whose unwritten words read as addr ^ 16'h5A5A.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, vid_req;
    logic [15:0] cpu_addr, cpu_wdata, vid_addr;

    logic        cpu_gnt1, cpu_rvalid1, vid_gnt1, vid_rvalid1, ram_en1, ram_we1;
    logic [15:0] cpu_rdata1, vid_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        cpu_gnt3, cpu_rvalid3, vid_gnt3, vid_rvalid3, ram_en3, ram_we3;
    logic [15:0] cpu_rdata3, vid_rdata3, ram_addr3, ram_wdata3, ram_rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .MAX_WAIT(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt1), .vid_rvalid(vid_rvalid1), .vid_rdata(vid_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3), .MAX_WAIT(8)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt3), .vid_rvalid(vid_rvalid3), .vid_rdata(vid_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3)
    );

    function automatic logic [15:0] base_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memories store value ^ base_val(addr) so zero-initialised words read as base_val.
    bit [15:0] mem1 [0:65535];
    bit [15:0] mem3 [0:65535];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wdata1 ^ base_val(ram_addr1);
            else         pipe1 <= mem1[ram_addr1] ^ base_val(ram_addr1);
        end
    end
    assign ram_rdata1 = pipe1;

    always @(posedge clk) begin
        if (ram_en3) begin
            if (ram_we3) mem3[ram_addr3] <= ram_wdata3 ^ base_val(ram_addr3);
            else         pipe3[0] <= mem3[ram_addr3] ^ base_val(ram_addr3);
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata3 = pipe3[2];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0010;
        cpu_wdata = 16'h0000;
        vid_req   = 1'b1;
        vid_addr  = 16'hC000;

        // Reset held with both requests pending
        repeat (3) tick();
        chk_val("rst_cpu_gnt", cpu_gnt1, 0);
        chk_val("rst_vid_gnt", vid_gnt1, 0);
        chk_val("rst_ram_en", ram_en1, 0);
        chk_val("rst_cpu_rvalid", cpu_rvalid1, 0);
        chk_val("rst_vid_rvalid", vid_rvalid1, 0);
        reset = 1'b1;
        #1;
        chk_val("rel_cpu_gnt", cpu_gnt1, 1);
        chk_val("rel_vid_gnt", vid_gnt1, 0);
        tick();
        idle(6);

        // CPU write then read-back of the same address
        chk_val("wr_idle_ram_en", ram_en1, 0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF;
        #1;
        chk_val("wr_cpu_gnt", cpu_gnt1, 1);
        tick();
        chk_val("wr_ram_en", ram_en1, 1);
        chk_val("wr_ram_we", ram_we1, 1);
        chk_val("wr_ram_addr", ram_addr1, 16'h3000);
        chk_val("wr_ram_wdata", ram_wdata1, 16'hBEEF);
        cpu_we = 1'b0; cpu_wdata = 16'h1234;
        #1;
        chk_val("rd_cpu_gnt", cpu_gnt1, 1);
        tick();
        cpu_req = 1'b0;
        chk_val("rd_ram_en", ram_en1, 1);
        chk_val("rd_ram_we", ram_we1, 0);
        chk_val("rd_early_rvalid", cpu_rvalid1, 0);
        tick();
        chk_val("rd_cpu_rvalid", cpu_rvalid1, 1);
        chk_val("rd_cpu_rdata", cpu_rdata1, 16'hBEEF);
        chk_val("rd_vid_rvalid", vid_rvalid1, 0);
        chk_val("rd_ram_en_off", ram_en1, 0);
        chk_val("rd_ram_addr_hold", ram_addr1, 16'h3000);
        tick();
        chk_val("rd_rvalid_once", cpu_rvalid1, 0);
        idle(6);

        // Video alone: four back-to-back fetches, returns two cycles after each grant
        for (int i = 0; i < 8; i++) begin
            vid_req  = (i < 4);
            vid_addr = 16'hC000 + 16'(i);
            #1;
            chk_val($sformatf("vid%0d_gnt", i), vid_gnt1, (i < 4) ? 1 : 0);
            chk_val($sformatf("vid%0d_cpu_gnt", i), cpu_gnt1, 0);
            chk_val($sformatf("vid%0d_rvalid", i), vid_rvalid1, (i >= 2 && i < 6) ? 1 : 0);
            chk_val($sformatf("vid%0d_cpu_rvalid", i), cpu_rvalid1, 0);
            if (i >= 2 && i < 6)
                chk_val($sformatf("vid%0d_rdata", i), vid_rdata1, base_val(16'hC000 + 16'(i - 2)));
            tick();
        end
        idle(6);

        // Starvation: both held, video forced in after eight refusals, twice
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        vid_req = 1'b1; vid_addr = 16'hC100;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk_val($sformatf("stv%0d_vid_gnt", i), vid_gnt1, (i == 8 || i == 17) ? 1 : 0);
            chk_val($sformatf("stv%0d_cpu_gnt", i), cpu_gnt1, (i == 8 || i == 17) ? 0 : 1);
            tick();
        end
        idle(8);

        // Mixed reads in flight, alternating owners
        for (int i = 0; i < 12; i++) begin
            cpu_req  = (i < 6) && (i % 2 == 0);
            cpu_we   = 1'b0;
            cpu_addr = 16'h0010;
            vid_req  = (i < 6) && (i % 2 == 1);
            vid_addr = 16'hC000;
            #1;
            chk_val($sformatf("mix%0d_l3_cpu_rvalid", i), cpu_rvalid3,
                    (i >= 4 && i < 10 && i % 2 == 0) ? 1 : 0);
            chk_val($sformatf("mix%0d_l3_vid_rvalid", i), vid_rvalid3,
                    (i >= 4 && i < 10 && i % 2 == 1) ? 1 : 0);
            chk_val($sformatf("mix%0d_l1_cpu_rvalid", i), cpu_rvalid1,
                    (i >= 2 && i < 8 && i % 2 == 0) ? 1 : 0);
            chk_val($sformatf("mix%0d_l1_vid_rvalid", i), vid_rvalid1,
                    (i >= 2 && i < 8 && i % 2 == 1) ? 1 : 0);
            if (i >= 4 && i < 10 && i % 2 == 0) chk_val($sformatf("mix%0d_l3_cpu_rdata", i), cpu_rdata3, 16'h5A4A);
            if (i >= 4 && i < 10 && i % 2 == 1) chk_val($sformatf("mix%0d_l3_vid_rdata", i), vid_rdata3, 16'h9A5A);
            tick();
        end
        idle(4);

        // Reset one cycle after a CPU read grant drops the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        #1;
        chk_val("mid_cpu_gnt", cpu_gnt1, 1);
        tick();
        cpu_req = 1'b0;
        chk_val("mid_ram_en_pre", ram_en1, 1);
        reset = 1'b0;
        #1;
        chk_val("mid_ram_en1", ram_en1, 0);
        chk_val("mid_ram_en3", ram_en3, 0);
        chk_val("mid_ram_addr", ram_addr1, 0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_val($sformatf("mid%0d_l1_rvalid", i), cpu_rvalid1, 0);
            chk_val($sformatf("mid%0d_l3_rvalid", i), cpu_rvalid3, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
